bcd_to_bin: RTL and testbench

Sequential packed-BCD to binary converter for the CPU's decimal-arithmetic support path. It does the inverse of decimal adjust: decimal adjust turns a binary ALU result into packed BCD, and this block turns a packed-BCD operand (for example a DAA-adjusted accumulator, or a BCD counter/score value) back into its binary value. It uses reverse double-dabble, processing one bit per clock, with valid/ready handshakes on the input and output sides.

---
 rtl/bcd_to_bin_if.sv | 25 ++
 rtl/bcd_to_bin.sv | 106 ++++++++++
 tb/tb_bcd_to_bin.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_bin_if.sv
// Handshake bundle for the packed-BCD to binary converter.
// Producer/consumer side is master, converter side is slave.
interface bcd_to_bin_if #(
   parameter int DIGITS = 4
);
   localparam int N = 4 * DIGITS;

   logic [N-1:0] i_bcd;
   logic         i_valid;
   logic         o_ready;
   logic [N-1:0] o_bin;
   logic         o_err;
   logic         o_valid;
   logic         i_ready;

   modport master (
      output i_bcd, i_valid, i_ready,
      input  o_ready, o_bin, o_err, o_valid
   );

   modport slave (
      input  i_bcd, i_valid, i_ready,
      output o_ready, o_bin, o_err, o_valid
   );
endinterface

// File: rtl/bcd_to_bin.sv
// Packed-BCD to binary converter, reverse double-dabble, one bit per clock.
// Optional digit range check: define BCD_TO_BIN_INVALID_CHECK_EN.
module bcd_to_bin #(
   parameter int DIGITS = 4
) (
   input logic         i_clk,
   input logic         i_rst,
   bcd_to_bin_if.slave bus
);
   localparam int N  = 4 * DIGITS;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   state_e         state_q, state_d;
   logic [2*N-1:0] w_q, w_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   bin_q, bin_d;
   logic           err_q, err_d;
   logic [2*N-1:0] w_adj;
   logic           bad_digit;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         w_q     <= '0;
         cnt_q   <= '0;
         bin_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         err_q   <= err_d;
      end
   end

   // Shift right, then pull 3 out of any BCD nibble that landed at >= 8.
   always_comb begin
      w_adj = w_q >> 1;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_adj[N+4*i+3]) begin
            w_adj[N+4*i +: 4] = w_adj[N+4*i +: 4] - 4'd3;
         end
      end
   end

`ifdef BCD_TO_BIN_INVALID_CHECK_EN
   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.i_bcd[4*i +: 4] > 4'd9) begin
            bad_digit = 1'b1;
         end
      end
   end
`else
   assign bad_digit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.i_valid) state_d = BUSY;
         BUSY:    if (cnt_q == CW'(1)) state_d = DONE;
         DONE:    if (bus.i_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      w_d   = w_q;
      cnt_d = cnt_q;
      bin_d = bin_q;
      err_d = err_q;
      unique case (state_q)
         IDLE: begin
            if (bus.i_valid) begin
               w_d   = {bus.i_bcd, {N{1'b0}}};
               cnt_d = CW'(N);
               err_d = bad_digit;
            end
         end
         BUSY: begin
            w_d   = w_adj;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               bin_d = w_adj[N-1:0];
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.o_ready = (state_q == IDLE);
      bus.o_valid = (state_q == DONE);
      bus.o_bin   = bin_q;
      bus.o_err   = err_q;
   end
endmodule

// File: tb/tb_bcd_to_bin.sv
// Randomized self-checking bench for bcd_to_bin (DIGITS=4 and DIGITS=2).
// Expected values come from a decimal-weight reference model.
module tb_bcd_to_bin;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   bcd_to_bin_if #(.DIGITS(4)) bus4();
   bcd_to_bin_if #(.DIGITS(2)) bus2();

   bcd_to_bin #(.DIGITS(4)) dut4 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus4.slave)
   );

   bcd_to_bin #(.DIGITS(2)) dut2 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus2.slave)
   );

   function automatic logic [15:0] ref_bin(input logic [15:0] bcd);
      int v = 0;
      int w = 1;
      for (int i = 0; i < 4; i++) begin
         v += int'(bcd[4*i +: 4]) * w;
         w *= 10;
      end
      return 16'(v);
   endfunction

   function automatic logic ref_err(input logic [15:0] bcd);
      logic e = 1'b0;
`ifdef BCD_TO_BIN_INVALID_CHECK_EN
      for (int i = 0; i < 4; i++) e |= (bcd[4*i +: 4] > 4'd9);
`endif
      return e;
   endfunction

   function automatic logic [15:0] rand_bcd();
      logic [15:0] b;
      for (int i = 0; i < 4; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string nm);
      int t = 0;
      while (!bus4.o_ready && t < 40) begin
         tick();
         t++;
      end
      if (!bus4.o_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s ready timeout: o_ready=%b want 1", nm, bus4.o_ready);
      end
   endtask

   task automatic run4(input logic [15:0] bcd, input bit chk_bin,
                       input bit rdy, input string nm);
      int lat;
      wait_ready(nm);
      bus4.i_bcd   = bcd;
      bus4.i_valid = 1'b1;
      bus4.i_ready = rdy;
      tick();
      bus4.i_valid = 1'b0;
      bus4.i_bcd   = 16'($urandom);
      lat = 0;
      while (!bus4.o_valid && lat < 40) begin
         tick();
         lat++;
      end
      n_tests++;
      if (lat !== 16) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want 16", nm, lat);
      end
      if (chk_bin) begin
         n_tests++;
         if (bus4.o_bin !== ref_bin(bcd)) begin
            n_fail++;
            $display("FAIL %s bin: got %h want %h", nm, bus4.o_bin,
                     ref_bin(bcd));
         end
      end
      n_tests++;
      if (bus4.o_err !== ref_err(bcd)) begin
         n_fail++;
         $display("FAIL %s err: got %b want %b", nm, bus4.o_err,
                  ref_err(bcd));
      end
      if (rdy) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_tests++;
      if ({bus4.o_ready, bus4.o_valid, bus4.o_err} !== 3'b100 ||
          bus4.o_bin !== 16'h0) begin
         n_fail++;
         $display("FAIL reset: rdy/vld/err=%b bin=%h want 100 0000",
                  {bus4.o_ready, bus4.o_valid, bus4.o_err}, bus4.o_bin);
      end
      n_tests++;
      if ({bus2.o_ready, bus2.o_valid} !== 2'b10 || bus2.o_bin !== 8'h0) begin
         n_fail++;
         $display("FAIL reset2: rdy/vld=%b bin=%h want 10 00",
                  {bus2.o_ready, bus2.o_valid}, bus2.o_bin);
      end
   endtask

   task automatic test_convert();
      run4(16'h1234, 1'b1, 1'b1, "c1234");
      run4(16'h9999, 1'b1, 1'b1, "c9999");
      run4(16'h0000, 1'b1, 1'b1, "c0000");
      for (int i = 0; i < 12; i++) run4(rand_bcd(), 1'b1, 1'b1, "rand");
   endtask

   task automatic test_digits2();
      int lat = 0;
      bus2.i_bcd   = 8'h99;
      bus2.i_valid = 1'b1;
      bus2.i_ready = 1'b1;
      tick();
      bus2.i_valid = 1'b0;
      while (!bus2.o_valid && lat < 40) begin
         tick();
         lat++;
      end
      n_tests++;
      if (lat !== 8 || bus2.o_bin !== ref_bin(16'h0099)) begin
         n_fail++;
         $display("FAIL d2 99: lat=%0d bin=%h want 8 %h", lat, bus2.o_bin,
                  ref_bin(16'h0099));
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [15:0] exp = ref_bin(16'h0357);
      run4(16'h0357, 1'b1, 1'b0, "bp");
      for (int i = 0; i < 5; i++) begin
         bus4.i_valid = i[0];
         bus4.i_bcd   = 16'h0888;
         tick();
         n_tests++;
         if ({bus4.o_valid, bus4.o_ready, bus4.o_err} !== 3'b100 ||
             bus4.o_bin !== exp) begin
            n_fail++;
            $display("FAIL bp hold: vld/rdy/err=%b bin=%h want 100 %h",
                     {bus4.o_valid, bus4.o_ready, bus4.o_err},
                     bus4.o_bin, exp);
         end
      end
      bus4.i_valid = 1'b0;
      bus4.i_ready = 1'b1;
      tick();
      n_tests++;
      if ({bus4.o_valid, bus4.o_ready} !== 2'b01 || bus4.o_bin !== exp) begin
         n_fail++;
         $display("FAIL bp handoff: vld/rdy=%b bin=%h want 01 %h",
                  {bus4.o_valid, bus4.o_ready}, bus4.o_bin, exp);
      end
      run4(16'h0888, 1'b1, 1'b1, "bp next");
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      wait_ready("rst mid");
      bus4.i_bcd   = 16'h5678;
      bus4.i_valid = 1'b1;
      bus4.i_ready = 1'b1;
      tick();
      bus4.i_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      rst = 1'b1;
      bus4.i_valid = 1'b1;
      tick();
      rst = 1'b0;
      bus4.i_valid = 1'b0;
      n_tests++;
      if ({bus4.o_valid, bus4.o_ready} !== 2'b01 || bus4.o_bin !== 16'h0) begin
         n_fail++;
         $display("FAIL rst mid: vld/rdy=%b bin=%h want 01 0000",
                  {bus4.o_valid, bus4.o_ready}, bus4.o_bin);
      end
      for (int i = 0; i < 20; i++) begin
         if (bus4.o_valid) seen++;
         tick();
      end
      n_tests++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL rst abort: valid cycles=%0d want 0", seen);
      end
      run4(16'h0042, 1'b1, 1'b1, "after rst");
   endtask

   task automatic test_invalid();
      run4(16'h12A4, 1'b0, 1'b1, "inv 12A4");
      run4(16'h0100, 1'b1, 1'b1, "inv 0100");
   endtask

   task automatic test_back_to_back();
      logic [15:0] vals [2] = '{16'h0001, 16'h0010};
      int acc_cyc [2] = '{0, 0};
      int acc = 0;
      int res = 0;
      int cyc = 0;
      wait_ready("b2b");
      bus4.i_ready = 1'b1;
      bus4.i_valid = 1'b1;
      bus4.i_bcd   = vals[0];
      while (res < 2 && cyc < 80) begin
         if (bus4.o_ready && acc < 2) begin
            bus4.i_bcd   = vals[acc];
            acc_cyc[acc] = cyc;
            acc++;
         end
         if (bus4.o_valid) begin
            n_tests++;
            if (bus4.o_bin !== ref_bin(vals[res])) begin
               n_fail++;
               $display("FAIL b2b res%0d: got %h want %h", res, bus4.o_bin,
                        ref_bin(vals[res]));
            end
            res++;
         end
         if (res == 2) bus4.i_valid = 1'b0;
         tick();
         cyc++;
      end
      bus4.i_valid = 1'b0;
      n_tests++;
      if (res !== 2 || acc_cyc[1] - acc_cyc[0] !== 18) begin
         n_fail++;
         $display("FAIL b2b spacing: results=%0d gap=%0d want 2 18", res,
                  acc_cyc[1] - acc_cyc[0]);
      end
      tick();
   endtask

   initial begin
      bus4.i_bcd   = '0;
      bus4.i_valid = 1'b0;
      bus4.i_ready = 1'b1;
      bus2.i_bcd   = '0;
      bus2.i_valid = 1'b0;
      bus2.i_ready = 1'b1;
      test_reset();
      test_convert();
      test_digits2();
      test_backpressure();
      test_reset_mid();
      test_invalid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
